// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants and types for the clk_div_multi divider slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int unsigned CLK_DIV_CNT_W_DFLT  = 24;
  localparam int unsigned CLK_DIV_DEFAULT_DIV = 10000000;

  // Counter/divisor type at the default width; instances with a different
  // CNT_W use an equivalent locally sized vector.
  typedef logic [CLK_DIV_CNT_W_DFLT-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// Module   : clk_div_chan
// Brief    : One divider channel: counter, active divisor, tick and clk_out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CLK_DIV_CNT_W_DFLT,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             align,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] C_RST_DIV = DEFAULT_DIV[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             w_terminal;

  assign w_terminal = (cnt_q == (div_q - C_ONE));

  // Priority: align, then disable (en low or zero divisor), then terminal count.
  // The divisor is only reloaded at period boundaries so a running period never shortens.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (align) begin
      cnt_d = '0;
      div_d = div_i;
      clk_d = 1'b0;
    end else if (!en || (div_q == '0)) begin
      cnt_d = '0;
      div_d = div_i;
    end else if (w_terminal) begin
      cnt_d  = '0;
      div_d  = div_i;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
    end else begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      div_q  <= C_RST_DIV;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Brief    : NCH independent programmable clock dividers / tick generators.
//            Define CLK_DIV_ALIGN_EN to add the synchronous phase-align port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = CLK_DIV_CNT_W_DFLT,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic               clk,
  input  logic               reset,
`ifdef CLK_DIV_ALIGN_EN
  input  logic               align,
`endif
  input  logic [NCH-1:0]       en,
  input  logic [NCH*CNT_W-1:0] div_i,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       clk_out
);

  logic w_align;

`ifdef CLK_DIV_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      clk_div_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .en      (en[c]),
        .align   (w_align),
        .div_i   (div_i[c*CNT_W +: CNT_W]),
        .tick    (tick[c]),
        .clk_out (clk_out[c])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed self-checking bench for clk_div_multi (NCH=2, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  logic        clk;
  logic        reset;
  logic [1:0]  en;
  logic [15:0] div_i;
  logic [1:0]  tick;
  logic [1:0]  clk_out;
`ifdef CLK_DIV_ALIGN_EN
  logic        align;
`endif

  int n_chk;
  int n_fail;

  clk_div_multi #(
    .NCH         (2),
    .CNT_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef CLK_DIV_ALIGN_EN
    .align   (align),
`endif
    .en      (en),
    .div_i   (div_i),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then compare both channels at the following falling edge.
  task automatic step_chk(input logic [1:0] et, input logic [1:0] ec, input string tag);
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    assert ({tick, clk_out} === {et, ec})
    else begin
      n_fail++;
      $error("FAIL %s: tick/clk_out = %b/%b, expected %b/%b", tag, tick, clk_out, et, ec);
    end
  endtask

  task automatic chk_cnt0(input logic [7:0] exp, input string tag);
    n_chk++;
    assert (dut.g_chan[0].u_chan.cnt_q === exp)
    else begin
      n_fail++;
      $error("FAIL %s: ch0 counter = %0d, expected %0d", tag, dut.g_chan[0].u_chan.cnt_q, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    en     = 2'b00;
    div_i  = {8'd5, 8'd3};
`ifdef CLK_DIV_ALIGN_EN
    align  = 1'b0;
`endif

    // Reset held over three clocks
    step_chk(2'b00, 2'b00, "rst_a");
    step_chk(2'b00, 2'b00, "rst_b");
    step_chk(2'b00, 2'b00, "rst_c");
    chk_cnt0(8'd0, "rst_cnt");

    // Release with one disabled edge so both channels pick up div_i
    reset = 1'b1;
    step_chk(2'b00, 2'b00, "load");
    en = 2'b11;
    for (int k = 1; k <= 15; k++)
      step_chk({(k % 5) == 0, (k % 3) == 0},
               {((k / 5) % 2) == 1, ((k / 3) % 2) == 1}, "t1_run");

    // ch0 div=1: tick continuous, clk_out = clk/2; ch1 frozen with clk_out=1
    div_i[7:0] = 8'd1;
    en = 2'b00;
    step_chk(2'b00, 2'b11, "t2_load1");
    en = 2'b01;
    step_chk(2'b01, 2'b10, "t2_d1_a");
    step_chk(2'b01, 2'b11, "t2_d1_b");
    step_chk(2'b01, 2'b10, "t2_d1_c");
    step_chk(2'b01, 2'b11, "t2_d1_d");

    // ch0 div=0 behaves as disabled
    div_i[7:0] = 8'd0;
    en = 2'b00;
    step_chk(2'b00, 2'b11, "t2_load0");
    en = 2'b01;
    for (int k = 0; k < 4; k++) step_chk(2'b00, 2'b11, "t2_d0");

    // Divisor change mid-period is deferred to the next terminal count
    div_i[7:0] = 8'd5;
    en = 2'b00;
    step_chk(2'b00, 2'b11, "t3_load5");
    en = 2'b01;
    for (int k = 0; k < 4; k++) step_chk(2'b00, 2'b11, "t3_cnt");
    step_chk(2'b01, 2'b10, "t3_tick_a");
    step_chk(2'b00, 2'b10, "t3_c1");
    step_chk(2'b00, 2'b10, "t3_c2");
    chk_cnt0(8'd2, "t3_cnt2");
    div_i[7:0] = 8'd2;
    step_chk(2'b00, 2'b10, "t3_c3");
    step_chk(2'b00, 2'b10, "t3_c4");
    step_chk(2'b01, 2'b11, "t3_old_div");
    step_chk(2'b00, 2'b11, "t3_n1");
    step_chk(2'b01, 2'b10, "t3_new_a");
    step_chk(2'b00, 2'b10, "t3_n2");
    step_chk(2'b01, 2'b11, "t3_new_b");

    // en dropped on a terminal edge with clk_out=1
    step_chk(2'b00, 2'b11, "t4_pre");
    en = 2'b00;
    step_chk(2'b00, 2'b11, "t4_drop");
    chk_cnt0(8'd0, "t4_cnt");
    en = 2'b01;
    step_chk(2'b00, 2'b11, "t4_re1");
    step_chk(2'b01, 2'b10, "t4_re2");

    // Async reset mid-period with counter=3 and clk_out=1
    div_i[7:0] = 8'd6;
    en = 2'b00;
    step_chk(2'b00, 2'b10, "t5_load6");
    en = 2'b01;
    for (int k = 0; k < 5; k++) step_chk(2'b00, 2'b10, "t5_cnt");
    step_chk(2'b01, 2'b11, "t5_tick");
    for (int k = 0; k < 3; k++) step_chk(2'b00, 2'b11, "t5_run");
    chk_cnt0(8'd3, "t5_cnt3");
    #2 reset = 1'b0;
    #1;
    n_chk++;
    assert ({tick, clk_out} === 4'b0000)
    else begin
      n_fail++;
      $error("FAIL t5_async: tick/clk_out = %b/%b, expected 00/00", tick, clk_out);
    end
    chk_cnt0(8'd0, "t5_async_cnt");

    // Reset divisor is DEFAULT_DIV=4 on both channels
    @(negedge clk);
    reset = 1'b1;
    en    = 2'b11;
    div_i = {8'd5, 8'd3};
    for (int k = 0; k < 3; k++) step_chk(2'b00, 2'b00, "dflt_cnt");
    step_chk(2'b11, 2'b11, "dflt_tick");

    // Largest divisor 2**CNT_W-1 on ch1
    en = 2'b00;
    div_i[15:8] = 8'd255;
    step_chk(2'b00, 2'b11, "max_load");
    en = 2'b10;
    for (int k = 1; k <= 255; k++)
      step_chk({k == 255, 1'b0}, {k != 255, 1'b1}, "max_run");

`ifdef CLK_DIV_ALIGN_EN
    // Align from arbitrary phases
    div_i = {8'd6, 8'd4};
    en    = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    align = 1'b1;
    step_chk(2'b00, 2'b00, "al_pulse");
    align = 1'b0;
    for (int k = 1; k <= 24; k++)
      step_chk({(k % 6) == 0, (k % 4) == 0},
               {((k / 6) % 2) == 1, ((k / 4) % 2) == 1}, "al_run");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
